// File: rtl/irq_controller.sv
// irq_controller: memory-mapped level/edge interrupt controller feeding the flow controller IRQ input
// Ports: clk, rst (async active-low); irqSrc raw sources; inputAddr/inputData/wrEn CPU write;
//        outputAddr CPU read address, outputData registered read data; irqOut masked pending, irqReq any.
// Map (word offsets from BASE_ADDR): +0 PENDING, +1 MASK, +2 CLEAR (W1C), +3 EDGESEL, +4 ACTIVE.
// Macro IRQ_SYNC_EN: adds a 2-flop synchroniser on every source (latency 4 instead of 2).
module irq_controller #(
  parameter int          N_SRC     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irqSrc,
  input  logic [31:0] inputAddr,
  input  logic [31:0] inputData,
  input  logic        wrEn,
  input  logic [31:0] outputAddr,
  output logic [31:0] outputData,
  output logic [31:0] irqOut,
  output logic        irqReq
);
  localparam logic [31:0] IMPL = N_SRC >= 32 ? 32'hFFFF_FFFF : 32'((64'h1 << N_SRC) - 64'h1);
  logic [31:0] src_s, src_prev, pending, mask, edge_sel;
  logic [31:0] wr_off, rd_off, edge_sel_n, clr, en, active, rd_val;
  logic [4:0]  active_id;
`ifdef IRQ_SYNC_EN
  logic [31:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irqSrc;
      sync2 <= sync1;
    end
  assign src_s = sync2;
`else
  assign src_s = irqSrc;
`endif
  assign wr_off     = inputAddr - BASE_ADDR;
  assign rd_off     = outputAddr - BASE_ADDR;
  assign edge_sel_n = wrEn && wr_off == 32'd3 ? inputData & IMPL : edge_sel;
  assign clr        = wrEn && wr_off == 32'd2 ? inputData : '0;
  assign en         = pending & mask;
  always_comb begin
    active_id = '0;
    for (int i = 31; i >= 0; i--)
      if (en[i]) active_id = 5'(i);
  end
  assign active = {|en, 26'd0, active_id};
  assign rd_val = rd_off == 32'd0 ? pending :
                  rd_off == 32'd1 ? mask :
                  rd_off == 32'd3 ? edge_sel :
                  rd_off == 32'd4 ? active : '0;
  // Edge bits: a new rising edge wins over a same-cycle clear; a mode change drops the bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      src_prev   <= '0;
      pending    <= '0;
      mask       <= '0;
      edge_sel   <= '0;
      outputData <= '0;
      irqOut     <= '0;
      irqReq     <= 1'b0;
    end else begin
      src_prev   <= src_s;
      pending    <= (edge_sel & ((pending & ~clr) | (src_s & ~src_prev)) | ~edge_sel & src_s)
                    & ~(edge_sel ^ edge_sel_n) & IMPL;
      mask       <= wrEn && wr_off == 32'd1 ? inputData & IMPL : mask;
      edge_sel   <= edge_sel_n;
      outputData <= rd_val;
      irqOut     <= en;
      irqReq     <= |en;
    end
endmodule
